// File: rtl/turn_timer.sv
// Per-turn countdown timer feeding the game FSM's timeout input.
// Optional low-time warning flag enabled by defining TURN_TIMER_WARN_EN.
module turn_timer #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int TURN_SECONDS  = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cancel,
   input  logic       hold,
   output logic       timeout,
   output logic       running,
   output logic [4:0] seconds_left,
   output logic       warn
);

   localparam int            PW           = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [4:0]    TURN_LOAD    = 5'(TURN_SECONDS);

   if (TICKS_PER_SEC < 2) begin : g_bad_ticks
      $error("turn_timer: TICKS_PER_SEC must be at least 2");
   end
   if (TURN_SECONDS < 1 || TURN_SECONDS > 31) begin : g_bad_seconds
      $error("turn_timer: TURN_SECONDS must be within 1..31");
   end

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      EXPIRED
   } state_t;

   state_t        state;
   logic [PW-1:0] prescaler;
   logic          tick;

   // The prescaler only advances in RUN with hold low, so a tick implies both.
   assign tick = (state == RUN) && !hold && (prescaler == PRESCALE_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         prescaler    <= '0;
         seconds_left <= '0;
         timeout      <= 1'b0;
         running      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments; the default below
         // is legally overridden by a later assignment in the same block.
         timeout <= 1'b0;
         if (start) begin
            state        <= RUN;
            prescaler    <= '0;
            seconds_left <= TURN_LOAD;
            running      <= 1'b1;
         end else begin
            case (state)
               RUN: begin
                  if (cancel) begin
                     state   <= IDLE;
                     running <= 1'b0;
                  end else if (tick) begin
                     prescaler <= '0;
                     if (seconds_left > 5'd1) begin
                        seconds_left <= seconds_left - 5'd1;
                     end else begin
                        seconds_left <= '0;
                        state        <= EXPIRED;
                        running      <= 1'b0;
                        timeout      <= 1'b1;
                     end
                  end else if (!hold) begin
                     prescaler <= prescaler + PW'(1);
                  end
               end
               EXPIRED: state <= IDLE;
               IDLE:    ;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef TURN_TIMER_WARN_EN
   logic warn_nxt;

   // Tracks running && seconds_left <= 3 for the values the FSM is about to load.
   always_comb begin
      // NOTE: default first so every path assigns warn_nxt and no latch is inferred.
      warn_nxt = warn;
      if (start) begin
         warn_nxt = (TURN_LOAD <= 5'd3);
      end else if (state != RUN || cancel) begin
         warn_nxt = 1'b0;
      end else if (tick) begin
         warn_nxt = (seconds_left > 5'd1) && (seconds_left <= 5'd4);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         warn <= 1'b0;
      end else begin
         warn <= warn_nxt;
      end
   end
`else
   assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_turn_timer.sv
// Self-checking bench for turn_timer: directed table, corner sequences and
// randomized traffic against an elapsed-time reference model.
module tb_turn_timer;

   localparam int TICKS = 4;
   localparam int TURN  = 3;
`ifdef TURN_TIMER_WARN_EN
   localparam bit WARN_BUILD = 1'b1;
`else
   localparam bit WARN_BUILD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       cancel = 1'b0;
   logic       hold = 1'b0;
   logic       timeout;
   logic       running;
   logic [4:0] seconds_left;
   logic       warn;

   turn_timer #(.TICKS_PER_SEC(TICKS), .TURN_SECONDS(TURN)) dut (
      .clk(clk), .rst(rst), .start(start), .cancel(cancel), .hold(hold),
      .timeout(timeout), .running(running), .seconds_left(seconds_left), .warn(warn)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model: counts un-held RUN cycles since the last start.
   bit m_active;
   int m_elapsed;
   int m_secs;
   bit m_to;

   function automatic void model_reset();
      m_active = 0; m_elapsed = 0; m_secs = 0; m_to = 0;
   endfunction

   function automatic void model_step(input bit s, input bit c, input bit h);
      m_to = 0;
      if (s) begin
         m_active = 1; m_elapsed = 0; m_secs = TURN;
      end else if (m_active && c) begin
         m_active = 0;
      end else if (m_active && !h) begin
         m_elapsed++;
         if (m_elapsed == TURN * TICKS) begin
            m_active = 0; m_secs = 0; m_to = 1;
         end else begin
            m_secs = TURN - m_elapsed / TICKS;
         end
      end
   endfunction

   // One clock: drive inputs, let the edge sample them, compare at the falling edge.
   task automatic cycle(input bit s, input bit c, input bit h);
      start = s; cancel = c; hold = h;
      @(posedge clk);
      model_step(s, c, h);
      @(negedge clk);
      check("model_seconds_left", seconds_left, m_secs);
      check("model_running", running, m_active);
      check("model_timeout", timeout, m_to);
      check("model_warn", warn, WARN_BUILD && m_active && m_secs <= 3);
   endtask

   typedef struct {
      bit         s;
      bit         c;
      bit         h;
      logic [4:0] exp_secs;
      bit         exp_run;
      bit         exp_to;
   } vec_t;

   vec_t vecs[15];
   int   first_to;

   initial begin
      // Full countdown: entry k is the state seen after edge E+k.
      vecs[0] = '{1, 0, 0, 5'd3, 1, 0};
      for (int k = 1; k <= 3; k++)  vecs[k] = '{0, 0, 0, 5'd3, 1, 0};
      for (int k = 4; k <= 7; k++)  vecs[k] = '{0, 0, 0, 5'd2, 1, 0};
      for (int k = 8; k <= 11; k++) vecs[k] = '{0, 0, 0, 5'd1, 1, 0};
      vecs[12] = '{0, 0, 0, 5'd0, 0, 1};
      vecs[13] = '{0, 0, 0, 5'd0, 0, 0};
      vecs[14] = '{0, 0, 0, 5'd0, 0, 0};

      // Reset held with start asserted.
      start = 1'b1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset_seconds_left", seconds_left, 0);
         check("reset_running", running, 0);
         check("reset_timeout", timeout, 0);
         check("reset_warn", warn, 0);
      end
      start = 1'b0;
      rst = 1'b1;
      cycle(0, 0, 0);

      for (int i = 0; i < 15; i++) begin
         cycle(vecs[i].s, vecs[i].c, vecs[i].h);
         check("table_seconds_left", seconds_left, vecs[i].exp_secs);
         check("table_running", running, vecs[i].exp_run);
         check("table_timeout", timeout, vecs[i].exp_to);
         check("table_warn", warn, WARN_BUILD && vecs[i].exp_run);
      end

      // Cancel at E+6: seconds freeze at 2, no timeout afterwards.
      cycle(1, 0, 0);
      for (int i = 1; i <= 5; i++) cycle(0, 0, 0);
      cycle(0, 1, 0);
      check("cancel_running", running, 0);
      check("cancel_seconds_left", seconds_left, 2);
      first_to = -1;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 0);
         if (timeout && first_to < 0) first_to = i;
      end
      check("cancel_no_timeout", first_to, -1);
      check("cancel_seconds_hold", seconds_left, 2);

      // Hold for 5 cycles mid-run delays expiry to E+17.
      cycle(1, 0, 0);
      first_to = -1;
      for (int k = 1; k <= 30; k++) begin
         cycle(0, 0, (k >= 4 && k <= 8));
         if (timeout && first_to < 0) first_to = k;
      end
      check("hold_timeout_edge", first_to, 17);

      // Restart at E+10 reloads and expires 12 cycles later.
      cycle(1, 0, 0);
      first_to = -1;
      for (int k = 1; k <= 30; k++) begin
         cycle(k == 10, 0, 0);
         if (k == 10) check("restart_seconds_left", seconds_left, 3);
         if (timeout && first_to < 0) first_to = k;
      end
      check("restart_timeout_edge", first_to, 22);

      // start and cancel together restart the count.
      cycle(1, 0, 0);
      first_to = -1;
      for (int k = 1; k <= 30; k++) begin
         cycle(k == 6, k == 6, 0);
         if (k == 6) begin
            check("start_cancel_running", running, 1);
            check("start_cancel_seconds_left", seconds_left, 3);
         end
         if (timeout && first_to < 0) first_to = k;
      end
      check("start_cancel_timeout_edge", first_to, 18);

      // cancel on the final tick suppresses timeout.
      cycle(1, 0, 0);
      first_to = -1;
      for (int k = 1; k <= 20; k++) begin
         cycle(0, k == 12, 0);
         if (k == 12) begin
            check("final_cancel_running", running, 0);
            check("final_cancel_seconds_left", seconds_left, 1);
         end
         if (timeout && first_to < 0) first_to = k;
      end
      check("final_cancel_no_timeout", first_to, -1);

      // start in the EXPIRED cycle: pulse finishes, count restarts.
      cycle(1, 0, 0);
      for (int k = 1; k <= 12; k++) cycle(0, 0, 0);
      check("expired_timeout_high", timeout, 1);
      cycle(1, 0, 0);
      check("expired_restart_timeout", timeout, 0);
      check("expired_restart_running", running, 1);
      check("expired_restart_seconds_left", seconds_left, 3);

      // Asynchronous reset mid-count clears outputs before the next edge.
      for (int k = 1; k <= 5; k++) cycle(0, 0, 0);
      #2 rst = 1'b0;
      #1;
      check("async_reset_running", running, 0);
      check("async_reset_seconds_left", seconds_left, 0);
      check("async_reset_timeout", timeout, 0);
      check("async_reset_warn", warn, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < 16; k++) cycle(0, 0, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(29) == 0, $urandom_range(49) == 0, $urandom_range(3) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/turn_timer.md
# turn_timer

Per-turn countdown timer for the game controller. It sits directly upstream of the game FSM and generates that FSM's `timeout` input. The controller pulses `start` whenever a player's attack turn begins and pulses `cancel` when the attack ends early. If the player does not act within `TURN_SECONDS`, the block emits a one-cycle `timeout` pulse, and the FSM hands the turn to a random attack. The remaining seconds are exported for the 7-segment display path.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per second tick; legal range ≥ 2.
- `TURN_SECONDS`, default 15: countdown length in seconds; legal range 1..31.

Ports:
- `clk` input 1: system clock; all state is updated on the rising edge.
- `rst` input 1: reset, asynchronous, active-low. While 0, all state is forced to its reset value.
- `start` input 1: single-cycle pulse that (re)loads and starts the countdown.
- `cancel` input 1: single-cycle pulse that stops the countdown without producing `timeout`.
- `hold` input 1: level; while 1 in RUN, the prescaler and the seconds count are frozen.
- `timeout` output 1: registered; one-cycle pulse when the countdown expires.
- `running` output 1: 1 while the block is in RUN.
- `seconds_left` output 5: remaining whole seconds, unsigned.
- `warn` output 1: low-time warning flag (see Configuration).

## Operation
- The state machine has three states: IDLE, RUN and EXPIRED. The state encoding is free.
- The prescaler is a counter of width `$clog2(TICKS_PER_SEC)`. It counts 0..`TICKS_PER_SEC`-1 in RUN while `hold`=0.
  - A tick occurs on the cycle the prescaler is at `TICKS_PER_SEC`-1. On a tick the prescaler wraps to 0.
- IDLE:
  - `start`=1: load `seconds_left`=`TURN_SECONDS`, clear the prescaler, go to RUN.
  - All other inputs are ignored.
- RUN:
  - A tick with `seconds_left`>1: decrement `seconds_left`.
  - A tick with `seconds_left`=1: set `seconds_left` to 0 and go to EXPIRED.
  - `cancel`=1: go to IDLE. `seconds_left` freezes at its current value.
  - `hold`=1: the prescaler and `seconds_left` both freeze. `running` stays 1.
- EXPIRED:
  - Lasts exactly one cycle with `timeout`=1, then the block goes to IDLE. `seconds_left` stays 0.
- Priority in every state: `start` > `cancel` > tick.
  - `start` in RUN or EXPIRED reloads and restarts the count. In EXPIRED the `timeout` pulse still completes in that cycle.
  - When `start` and `cancel` are asserted together, the result is a restart.
  - `cancel` in the same cycle as the final tick suppresses `timeout`.
- `running` = (state==RUN).
- `timeout` = (state==EXPIRED). It is never asserted for 2 consecutive cycles.
- Reset values: state IDLE, prescaler 0, `seconds_left`=0, `timeout`=0, `running`=0, `warn`=0.
- Reset mid-count aborts immediately. No `timeout` is produced.

## Timing
- Outputs are registered: each changes one cycle after the edge that samples the causing input.
- With `start` sampled at edge E and `hold`/`cancel` held low:
  - `seconds_left` decrements at edges E+k·`TICKS_PER_SEC`, for k=1..`TURN_SECONDS`.
  - `timeout` is high for the single cycle after edge E+`TURN_SECONDS`·`TICKS_PER_SEC`.
- Each cycle with `hold`=1 in RUN delays expiry by exactly one cycle.
- Asynchronous reset assertion clears all outputs without waiting for a clock edge. Deassertion is synchronized externally.

## Configuration
- `TURN_TIMER_WARN_EN` defined:
  - `warn` = `running` && (`seconds_left` ≤ 3), registered together with `seconds_left`.
  - `warn` drives the blink request for the display path.
- `TURN_TIMER_WARN_EN` undefined:
  - `warn` is tied to 0 and no warning logic is synthesized.
  - The port remains present in both builds.

## Test plan
Bench parameters: `TICKS_PER_SEC`=4, `TURN_SECONDS`=3.
- **Reset:** hold `rst`=0 for 2 cycles with `start`=1 → `seconds_left`=0, `running`=0, `timeout`=0 throughout. `start` has no effect while reset is asserted.
- **Full countdown:** `start` pulse at edge E → `seconds_left` reads 3,2,1,0 at E+1, E+5, E+9, E+13. `timeout` is high only during the cycle after E+12, then `running`=0.
- **Cancel:** `start` pulse, then `cancel` at E+6 → `running`=0 from the next cycle, `seconds_left` holds 2, and `timeout` never asserts within 20 cycles.
- **Hold:** `start` pulse, then `hold`=1 for 5 cycles mid-run → `timeout` is delayed to the cycle after E+17.
- **Restart and priority:**
  - `start` re-pulsed at E+10 reloads `seconds_left`=3, and the next `timeout` follows 12 cycles later.
  - `start`+`cancel` asserted together gives a restart.
  - `cancel` coinciding with the final tick produces no `timeout`.
- **Warn, both builds:** with `TURN_TIMER_WARN_EN` defined, `warn`=1 from the first cycle of the run (`seconds_left`=3) and 0 after expiry. With the macro undefined, `warn`=0 throughout.
